// File: rtl/pu_fram_arb_pkg.sv
// Shared types and the round-robin pick helper for pu_fram arbiters.
package pu_fram_arb_pkg;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned IDW      = (MAX_NREQ > 2) ? $clog2(MAX_NREQ) : 1;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic           fwd;
  } resp_pipe_t;

  typedef struct packed {
    logic           found;
    logic [IDW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid_mask at or above rr_ptr, wrapping modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid_mask,
                                       input logic [IDW-1:0]      rr_ptr,
                                       input int unsigned         nreq);
    rr_pick_t       res;
    logic [IDW-1:0] j;
    res = '0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      j = IDW'((32'(rr_ptr) + k) % nreq);
      if (k < nreq && !res.found && valid_mask[j]) begin
        res.found = 1'b1;
        res.idx   = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pu_fram_arbiter_if.sv
// Requester-side bus of the pu_fram arbiter: flattened request fields and read responses.
interface pu_fram_arbiter_if #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ATTR_WIDTH = 4
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            req_wr;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ*ATTR_WIDTH-1:0] req_attr;
  logic [NREQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]      resp_data;
  logic [ATTR_WIDTH-1:0]      resp_attr;

  modport master (
    output req_valid, req_wr, req_addr, req_data, req_attr,
    input  req_ready, resp_valid, resp_data, resp_attr
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, req_attr,
    output req_ready, resp_valid, resp_data, resp_attr
  );
endinterface

// File: rtl/pu_fram_arbiter_rr_select.sv
// Pure round-robin priority picker: request mask + pointer -> one-hot grant and index.
module pu_fram_arbiter_rr_select
  import pu_fram_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] mask_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            found_o
);
  rr_pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_NREQ'(mask_i), ptr_i, NREQ);
    found_o = pick.found;
    idx_o   = pick.idx;
    grant_o = pick.found ? (NREQ'(1) << pick.idx) : '0;
  end
endmodule

// File: rtl/pu_fram_arbiter.sv
// Round-robin arbiter sharing one pu_fram bank; stalls reads that hit the pending write.
// Define PU_FRAM_ARB_FORWARD_EN to forward the pending write data instead of stalling.
module pu_fram_arbiter
  import pu_fram_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned RAM_SIZE   = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ATTR_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  pu_fram_arbiter_if.slave      req_bus,
  output logic [ADDR_WIDTH-1:0] signal_addr,
  output logic                  signal_wr,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ATTR_WIDTH-1:0] attr_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic [ATTR_WIDTH-1:0] attr_out
);
  if (NREQ < 2 || NREQ > MAX_NREQ || ADDR_WIDTH != $clog2(RAM_SIZE)) begin : g_bad_cfg
    $error("pu_fram_arbiter: unsupported parameter combination");
  end

  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]       hazard, elig, grant;
  logic [IDW-1:0]        win_idx;
  logic                  win_found, win_hit;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ATTR_WIDTH-1:0] attr_q, attr_d;
  logic                  wr_q, wr_d, oe_q, oe_d, sel_wr;
  resp_pipe_t            pipe0_q, pipe0_d, pipe1_q;

  // wr_q/addr_q double as the record of the write currently being issued to the bank.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      hazard[i] = req_bus.req_valid[i] & ~req_bus.req_wr[i] & wr_q &
                  (req_bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == addr_q);
    end
`ifdef PU_FRAM_ARB_FORWARD_EN
    elig = req_bus.req_valid;
`else
    elig = req_bus.req_valid & ~hazard;
`endif
  end

  pu_fram_arbiter_rr_select #(
    .NREQ(NREQ)
  ) u_rr_select (
    .mask_i (elig),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant),
    .idx_o  (win_idx),
    .found_o(win_found)
  );

  assign req_bus.req_ready = grant;
  assign win_hit           = |(grant & hazard);

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    attr_d   = attr_q;
    sel_wr   = 1'b0;
    wr_d     = 1'b0;
    oe_d     = 1'b0;
    rr_ptr_d = rr_ptr_q;
    pipe0_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        addr_d = req_bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_d = req_bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        attr_d = req_bus.req_attr[i*ATTR_WIDTH +: ATTR_WIDTH];
        sel_wr = req_bus.req_wr[i];
      end
    end
    if (win_found) begin
      wr_d          = sel_wr;
      oe_d          = ~sel_wr;
      rr_ptr_d      = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      pipe0_d.valid = ~sel_wr;
      pipe0_d.id    = win_idx;
      pipe0_d.fwd   = ~sel_wr & win_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      attr_q   <= '0;
      wr_q     <= 1'b0;
      oe_q     <= 1'b0;
      pipe0_q  <= '0;
      pipe1_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      attr_q   <= attr_d;
      wr_q     <= wr_d;
      oe_q     <= oe_d;
      pipe0_q  <= pipe0_d;
      pipe1_q  <= pipe0_q;
    end
  end

  assign signal_addr = addr_q;
  assign signal_wr   = wr_q;
  assign signal_oe   = oe_q;
  assign data_in     = data_q;
  assign attr_in     = attr_q;

`ifdef PU_FRAM_ARB_FORWARD_EN
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [ATTR_WIDTH-1:0] fwd_attr_q;

  // No other hit can be granted before this read's response slot, so one register suffices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_data_q <= '0;
      fwd_attr_q <= '0;
    end else if (pipe0_d.fwd) begin
      fwd_data_q <= data_q;
      fwd_attr_q <= attr_q;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = pipe1_q.fwd;
`endif

  always_comb begin
    req_bus.resp_valid = '0;
    req_bus.resp_data  = '0;
    req_bus.resp_attr  = '0;
    if (pipe1_q.valid) begin
      req_bus.resp_valid = NREQ'(1) << pipe1_q.id;
      req_bus.resp_data  = data_out;
      req_bus.resp_attr  = attr_out;
`ifdef PU_FRAM_ARB_FORWARD_EN
      if (pipe1_q.fwd) begin
        req_bus.resp_data = fwd_data_q;
        req_bus.resp_attr = fwd_attr_q;
      end
`endif
    end
  end
endmodule

// File: tb/tb_pu_fram_arbiter.sv
// Directed bench for pu_fram_arbiter with a behavioural pu_fram bank (write commits one cycle late).
module tb_pu_fram_arbiter;
  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned TW   = 4;
`ifdef PU_FRAM_ARB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pu_fram_arbiter_if #(
    .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ATTR_WIDTH(TW)
  ) bus ();

  logic [AW-1:0] signal_addr;
  logic          signal_wr, signal_oe;
  logic [DW-1:0] data_in, data_out;
  logic [TW-1:0] attr_in, attr_out;

  pu_fram_arbiter #(
    .NREQ(NREQ), .RAM_SIZE(16), .DATA_WIDTH(DW), .ATTR_WIDTH(TW), .ADDR_WIDTH(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_bus    (bus),
    .signal_addr(signal_addr),
    .signal_wr  (signal_wr),
    .signal_oe  (signal_oe),
    .data_in    (data_in),
    .attr_in    (attr_in),
    .data_out   (data_out),
    .attr_out   (attr_out)
  );

  // Bank model: registered read, write committed on the edge after it is presented.
  logic [DW-1:0] mem  [16];
  logic [TW-1:0] amem [16];
  logic          wr_d1;
  logic [AW-1:0] wa_d1;
  logic [DW-1:0] wd_d1;
  logic [TW-1:0] wt_d1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]  <= 32'hA000_0000 + 32'(i);
        amem[i] <= 4'(i);
      end
      wr_d1 <= 1'b0;
    end else begin
      if (wr_d1) begin
        mem[wa_d1]  <= wd_d1;
        amem[wa_d1] <= wt_d1;
      end
      wr_d1 <= signal_wr;
      wa_d1 <= signal_addr;
      wd_d1 <= data_in;
      wt_d1 <= attr_in;
      if (signal_oe) begin
        data_out <= mem[signal_addr];
        attr_out <= amem[signal_addr];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input bit v, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [TW-1:0] t);
    bus.req_valid[i]          = v;
    bus.req_wr[i]             = wr;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_data[i*DW +: DW]  = d;
    bus.req_attr[i*TW +: TW]  = t;
  endtask

  task automatic check_resp(input string tag, input logic [1:0] v, input logic [DW-1:0] d,
                            input logic [TW-1:0] t);
    check_eq({tag, "_rv"}, bus.resp_valid, v);
    if (v != 2'b00) begin
      check_eq({tag, "_rd"}, bus.resp_data, d);
      check_eq({tag, "_ra"}, bus.resp_attr, t);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_attr  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready", bus.req_ready, 0);
    check_eq("rst_resp", {bus.resp_valid, bus.resp_data, bus.resp_attr}, 0);
    check_eq("rst_sig", {signal_wr, signal_oe, signal_addr, attr_in}, 0);
    tick();
    rst = 1'b0;

    // Idle
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("idle", {signal_wr, signal_oe, bus.resp_valid}, 0);
      tick();
    end

    // Fairness: both read continuously for 6 cycles
    for (int k = 0; k < 8; k++) begin
      drive(0, k < 6, 1'b0, 4'd1, '0, '0);
      drive(1, k < 6, 1'b0, 4'd2, '0, '0);
      @(negedge clk);
      check_eq("fair_ready", bus.req_ready, (k >= 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10));
      if (k >= 2)
        check_resp("fair", (k % 2 == 0) ? 2'b01 : 2'b10,
                   (k % 2 == 0) ? 32'hA000_0001 : 32'hA000_0002, (k % 2 == 0) ? 4'd1 : 4'd2);
      else
        check_eq("fair_rv0", bus.resp_valid, 0);
      if (k >= 1 && k <= 6) check_eq("fair_oe", signal_oe, 1);
      tick();
    end

    // Write addr 3 then read addr 3 from the other requester
    for (int k = 0; k < 5; k++) begin
      int rk;
      logic [1:0] er;
      rk = FWD ? 3 : 4;
      case (k)
        0: begin drive(0, 1, 1, 4'd3, 32'hDEAD_BEEF, 4'h5); er = 2'b01; end
        1: begin drive(0, 0, 0, 4'd0, '0, '0); drive(1, 1, 0, 4'd3, '0, '0);
                 er = FWD ? 2'b10 : 2'b00; end
        2: begin drive(1, !FWD, 0, 4'd3, '0, '0); er = FWD ? 2'b00 : 2'b10; end
        default: begin drive(1, 0, 0, 4'd0, '0, '0); er = 2'b00; end
      endcase
      @(negedge clk);
      check_eq("haz_ready", bus.req_ready, er);
      if (k == 1) check_eq("haz_issue", {signal_wr, signal_addr, data_in}, {1'b1, 4'd3, 32'hDEAD_BEEF});
      check_resp("haz", (k == rk) ? 2'b10 : 2'b00, 32'hDEAD_BEEF, 4'h5);
      tick();
    end

    // Hazard-blocked requester loses the slot to the other requester
    for (int k = 0; k < 5; k++) begin
      logic [1:0] er;
      case (k)
        0: begin drive(0, 1, 1, 4'd7, 32'hCAFE_F00D, 4'h9); er = 2'b01; end
        1: begin drive(0, 1, 0, 4'd8, '0, '0); drive(1, 1, 0, 4'd7, '0, '0);
                 er = FWD ? 2'b10 : 2'b01; end
        2: begin drive(0, FWD, 0, 4'd8, '0, '0); drive(1, !FWD, 0, 4'd7, '0, '0);
                 er = FWD ? 2'b01 : 2'b10; end
        default: begin drive(0, 0, 0, 4'd0, '0, '0); drive(1, 0, 0, 4'd0, '0, '0); er = 2'b00; end
      endcase
      @(negedge clk);
      check_eq("alt_ready", bus.req_ready, er);
      if ((k == 3) == FWD)
        check_resp("alt1", (k >= 3) ? 2'b10 : 2'b00, 32'hCAFE_F00D, 4'h9);
      else
        check_resp("alt0", (k >= 3) ? 2'b01 : 2'b00, 32'hA000_0008, 4'h8);
      tick();
    end

    // Non-hazard: write addr 3, read addr 4 back-to-back
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive(0, 1, 1, 4'd3, 32'h1234_5678, 4'hA);
        1: begin drive(0, 0, 0, 4'd0, '0, '0); drive(1, 1, 0, 4'd4, '0, '0); end
        default: drive(1, 0, 0, 4'd0, '0, '0);
      endcase
      @(negedge clk);
      check_eq("nh_ready", bus.req_ready, (k == 0) ? 2'b01 : ((k == 1) ? 2'b10 : 2'b00));
      check_eq("nh_wr_oe", {signal_wr, signal_oe}, (k == 1) ? 2'b10 : ((k == 2) ? 2'b01 : 2'b00));
      if (k == 2) check_eq("nh_addr", signal_addr, 4);
      check_resp("nh", (k == 3) ? 2'b10 : 2'b00, 32'hA000_0004, 4'h4);
      tick();
    end

    // Back-pressure: both valid, req1 holds until granted
    for (int k = 0; k < 4; k++) begin
      drive(0, k == 0, 0, 4'd5, '0, '0);
      drive(1, k <= 1, 0, 4'd6, '0, '0);
      @(negedge clk);
      check_eq("bp_ready", bus.req_ready, (k == 0) ? 2'b01 : ((k == 1) ? 2'b10 : 2'b00));
      if (k == 2) check_resp("bp0", 2'b01, 32'hA000_0005, 4'h5);
      if (k == 3) check_resp("bp1", 2'b10, 32'hA000_0006, 4'h6);
      tick();
    end

    // Reset mid-read: read granted, reset during its issue cycle
    drive(0, 1, 0, 4'd1, 32'h5555_5555, 4'h3);
    @(negedge clk);
    check_eq("mr_ready", bus.req_ready, 2'b01);
    tick();
    drive(0, 0, 0, 4'd0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_sig", {signal_wr, signal_oe, signal_addr, data_in, attr_in}, 0);
    check_eq("mr_rv_a", bus.resp_valid, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mr_rv_b", bus.resp_valid, 0);
    check_eq("mr_sig_b", {signal_wr, signal_oe, signal_addr, data_in, attr_in}, 0);
    tick();
    @(negedge clk);
    check_eq("mr_rv_c", bus.resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
